mux8_to1_scanner: RTL and testbench

MUX8_TO1_SCANNER -- requirements
Module: mux8_to1_scanner

---
 rtl/mux8_to1_scanner.sv | 90 +++++++++
 tb/tb_mux8_to1_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_to1_scanner.sv
// Eight-line 1-bit mux with a registered output, valid/ready handshake on y,
// and an auto-scan mode that collects one bit per line into an 8-bit frame.
module mux8_to1_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic       d5,
  input  logic       d6,
  input  logic       d7,
  input  logic       out_ready,
  output logic       y,
  output logic       out_valid,
  output logic       idx0,
  output logic       idx1,
  output logic       idx2,
  output logic [7:0] frame,
  output logic       frame_valid
);

  logic [7:0] d_bus;
  logic [2:0] cnt;
  logic [2:0] sel;
  logic [2:0] idx;
  logic       load;
  logic       accept;
  logic       scan_load;
  logic       scan_last;

  assign d_bus = {d7, d6, d5, d4, d3, d2, d1, d0};

  always_comb begin
    sel       = mode ? cnt : {s2, s1, s0};
    load      = en && (!out_valid || out_ready);
    accept    = out_valid && out_ready;
    scan_load = load && mode;
    scan_last = scan_load && (cnt == 3'd7);
  end

  // Output sample register: a load can replace an accepted sample in the
  // same cycle, so out_valid only drops on acceptance without a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= 1'b0;
      idx       <= 3'd0;
      out_valid <= 1'b0;
    end else if (load) begin
      y         <= d_bus[sel];
      idx       <= sel;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  // Scan counter is held at zero in manual mode so a partial scan is dropped
  // and the next scan always begins at line 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (!mode) begin
      cnt <= 3'd0;
    end else if (scan_load) begin
      cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame       <= 8'h00;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= scan_last;
      if (scan_load) begin
        frame[cnt] <= d_bus[cnt];
      end
    end
  end

  assign {idx2, idx1, idx0} = idx;

endmodule

// File: tb/tb_mux8_to1_scanner.sv
// Directed self-checking bench for mux8_to1_scanner.
module tb_mux8_to1_scanner;

  logic clk = 1'b0;
  logic rst, en, mode, s0, s1, s2;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic out_ready;
  logic y, out_valid, idx0, idx1, idx2, frame_valid;
  logic [7:0] frame;

  int checks = 0;
  int failures = 0;

  mux8_to1_scanner dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .s0(s0), .s1(s1), .s2(s2),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .out_ready(out_ready), .y(y), .out_valid(out_valid),
    .idx0(idx0), .idx1(idx1), .idx2(idx2),
    .frame(frame), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [7:0] v);
    {d7, d6, d5, d4, d3, d2, d1, d0} = v;
  endtask

  task automatic set_s(input logic [2:0] v);
    {s2, s1, s0} = v;
  endtask

  function automatic logic [2:0] idx_now();
    return {idx2, idx1, idx0};
  endfunction

  task automatic expect_zero(input string name);
    checks++;
    if (y !== 1'b0 || out_valid !== 1'b0 || idx_now() !== 3'd0 ||
        frame !== 8'h00 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s y=%b ov=%b idx=%0d frame=%h fv=%b, required all zero",
               name, y, out_valid, idx_now(), frame, frame_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; out_ready = 1'b1; mode = 1'b0;
    set_d(8'hFF); set_s(3'd7);
    tick();
    expect_zero("reset");
    rst = 1'b0;
  endtask

  task automatic test_manual();
    logic [7:0] exp_y;
    exp_y = 8'b1010_0101;
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    set_d(8'b1010_0101);
    for (int i = 0; i < 8; i++) begin
      set_s(3'(i));
      tick();
      checks++;
      if (y !== exp_y[i] || idx_now() !== 3'(i) || out_valid !== 1'b1 ||
          frame !== 8'h00 || frame_valid !== 1'b0) begin
        failures++;
        $display("FAIL manual_s%0d y=%b idx=%0d ov=%b frame=%h fv=%b, required y=%b idx=%0d ov=1 frame=00 fv=0",
                 i, y, idx_now(), out_valid, frame, frame_valid, exp_y[i], i);
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || y !== 1'b1 || idx_now() !== 3'd7) begin
      failures++;
      $display("FAIL manual_accept ov=%b y=%b idx=%0d, required ov=0 y=1 idx=7",
               out_valid, y, idx_now());
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; en = 1'b1; out_ready = 1'b0;
    set_d(8'h08); set_s(3'd3);
    tick();
    checks++;
    if (y !== 1'b1 || idx_now() !== 3'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_load y=%b idx=%0d ov=%b, required y=1 idx=3 ov=1",
               y, idx_now(), out_valid);
    end
    set_d(8'h00); set_s(3'd5);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (y !== 1'b1 || idx_now() !== 3'd3 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d y=%b idx=%0d ov=%b, required y=1 idx=3 ov=1",
                 i, y, idx_now(), out_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (y !== 1'b0 || idx_now() !== 3'd5 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release y=%b idx=%0d ov=%b, required y=0 idx=5 ov=1",
               y, idx_now(), out_valid);
    end
    en = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain ov=%b, required 0", out_valid);
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] pat;
    logic [7:0] mask;
    pat = 8'hC3;
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    set_d(pat);
    for (int i = 0; i < 8; i++) begin
      tick();
      mask = 8'((9'd2 << i) - 9'd1);
      checks++;
      if (idx_now() !== 3'(i) || y !== pat[i] || frame !== (pat & mask) ||
          frame_valid !== (i == 7)) begin
        failures++;
        $display("FAIL scan_load%0d idx=%0d y=%b frame=%h fv=%b, required idx=%0d y=%b frame=%h fv=%b",
                 i, idx_now(), y, frame, frame_valid, i, pat[i], pat & mask, (i == 7));
      end
    end
    tick();
    checks++;
    if (idx_now() !== 3'd0 || frame_valid !== 1'b0 || frame !== 8'hC3) begin
      failures++;
      $display("FAIL scan_wrap idx=%0d fv=%b frame=%h, required idx=0 fv=0 frame=c3",
               idx_now(), frame_valid, frame);
    end
  endtask

  task automatic test_mode_abort();
    rst = 1'b1;
    tick();
    expect_zero("abort_reset_priority");
    rst = 1'b0;
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    set_d(8'h5A);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (idx_now() !== 3'(i)) begin
        failures++;
        $display("FAIL abort_load%0d idx=%0d, required %0d", i, idx_now(), i);
      end
    end
    mode = 1'b0; set_s(3'd6); set_d(8'hFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (frame_valid !== 1'b0 || frame !== 8'h0A) begin
        failures++;
        $display("FAIL abort_manual%0d fv=%b frame=%h, required fv=0 frame=0a",
                 i, frame_valid, frame);
      end
    end
    mode = 1'b1;
    tick();
    checks++;
    if (idx_now() !== 3'd0 || y !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart idx=%0d y=%b, required idx=0 y=1", idx_now(), y);
    end
  endtask

  task automatic test_reset_midscan();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    set_d(8'hFF);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    expect_zero("midscan_reset");
    rst = 1'b0;
    set_d(8'h3C);
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (idx_now() !== 3'(i) || frame_valid !== (i == 7)) begin
        failures++;
        $display("FAIL midscan_load%0d idx=%0d fv=%b, required idx=%0d fv=%b",
                 i, idx_now(), frame_valid, i, (i == 7));
      end
    end
    checks++;
    if (frame !== 8'h3C) begin
      failures++;
      $display("FAIL midscan_frame frame=%h, required 3c", frame);
    end
  endtask

  task automatic test_idle_en();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    set_d(8'hFF);
    tick();
    tick();
    en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || frame_valid !== 1'b0 || idx_now() !== 3'd1) begin
        failures++;
        $display("FAIL idle%0d ov=%b fv=%b idx=%0d, required ov=0 fv=0 idx=1",
                 i, out_valid, frame_valid, idx_now());
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (idx_now() !== 3'd2 || out_valid !== 1'b1 || frame !== 8'h07) begin
      failures++;
      $display("FAIL idle_resume idx=%0d ov=%b frame=%h, required idx=2 ov=1 frame=07",
               idx_now(), out_valid, frame);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; out_ready = 1'b0;
    set_s(3'd0); set_d(8'h00);
    test_reset();
    test_manual();
    test_backpressure();
    test_full_scan();
    test_mode_abort();
    test_reset_midscan();
    test_idle_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
